vga_timing_gen: RTL

- Parametrised raster timing generator and successor to the fixed 640x480 generator.
- Produces column/row coordinates, HSYNC/VSYNC, a visible-area flag and line/frame start strobes for any mode described by its porch/sync parameters.
- Adds a pixel clock-enable, selectable sync polarity, and a programmable output latency so sync/valid line up with a downstream pixel pipeline.
- Sits between the clock source and the framebuffer/pattern logic feeding the VGA pins.

---
 rtl/vga_timing_gen.sv | 128 ++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator.
// Column/row counters advance on pix_en; sync/valid/strobe decode can be
// delayed by LAT pixel steps to line up with a downstream pixel pipeline.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int COL_W    = 10,
    parameter int ROW_W    = 10,
    parameter int LAT      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    output logic             HSYNC,
    output logic             VSYNC,
    output logic             valid,
    output logic             line_start,
    output logic             frame_start,
    output logic [COL_W-1:0] curr_col,
    output logic [ROW_W-1:0] curr_row
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Parameter sanity: reject modes the counters cannot represent.
    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
        COL_W == 0 || ROW_W == 0) begin : g_err_zero
        $error("vga_timing_gen: timing parameters and widths must be non-zero");
    end
    if (COL_W > 30 || (H_TOTAL - 1) >= (1 << COL_W)) begin : g_err_colw
        $error("vga_timing_gen: COL_W too small for H_TOTAL-1");
    end
    if (ROW_W > 30 || (V_TOTAL - 1) >= (1 << ROW_W)) begin : g_err_roww
        $error("vga_timing_gen: ROW_W too small for V_TOTAL-1");
    end
    if (LAT < 0 || LAT > 7) begin : g_err_lat
        $error("vga_timing_gen: LAT must be 0..7");
    end

    localparam logic [COL_W-1:0] H_LAST   = COL_W'(H_TOTAL - 1);
    localparam logic [COL_W-1:0] H_VIS    = COL_W'(H_ACTIVE);
    localparam logic [COL_W-1:0] HS_START = COL_W'(H_ACTIVE + H_FP);
    localparam logic [COL_W-1:0] HS_END   = COL_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [ROW_W-1:0] V_LAST   = ROW_W'(V_TOTAL - 1);
    localparam logic [ROW_W-1:0] V_VIS    = ROW_W'(V_ACTIVE);
    localparam logic [ROW_W-1:0] VS_START = ROW_W'(V_ACTIVE + V_FP);
    localparam logic [ROW_W-1:0] VS_END   = ROW_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic             HP       = H_POL[0];
    localparam logic             VP       = V_POL[0];

    // All-zero is the inactive/reset value of every field.
    typedef struct packed {
        logic h_act;
        logic v_act;
        logic vis;
        logic ls;
        logic fs;
    } dec_t;

    dec_t dec0;
    dec_t dec_o;
    dec_t dec_out;

    // Raster counters: column wraps at H_LAST and carries into the row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            curr_col <= '0;
            curr_row <= '0;
        end else if (pix_en) begin
            if (curr_col == H_LAST) begin
                curr_col <= '0;
                if (curr_row == V_LAST) curr_row <= '0;
                else                    curr_row <= curr_row + 1'b1;
            end else begin
                curr_col <= curr_col + 1'b1;
            end
        end
    end

    // Stage-0 decode of the current counter position.
    always_comb begin
        dec0       = '0;
        dec0.h_act = (curr_col >= HS_START) && (curr_col < HS_END);
        dec0.v_act = (curr_row >= VS_START) && (curr_row < VS_END);
        dec0.vis   = (curr_col < H_VIS) && (curr_row < V_VIS);
        dec0.ls    = (curr_col == '0);
        dec0.fs    = (curr_col == '0) && (curr_row == '0);
    end

    if (LAT == 0) begin : g_nolat
        assign dec_o = dec0;
    end else begin : g_lat
        dec_t dec_pipe [1:LAT];

        // Delay line stepped by pix_en so it tracks pixels, not clocks.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 1; i <= LAT; i++) dec_pipe[i] <= '0;
            end else if (pix_en) begin
                dec_pipe[1] <= dec0;
                for (int i = 2; i <= LAT; i++) dec_pipe[i] <= dec_pipe[i-1];
            end
        end

        assign dec_o = dec_pipe[LAT];
    end

    // Reset masks the decode: with LAT=0 the counters sit at (0,0) during
    // reset, which would otherwise show as visible plus both strobes.
    assign dec_out = rst ? '0 : dec_o;

    assign HSYNC       = dec_out.h_act ? HP : ~HP;
    assign VSYNC       = dec_out.v_act ? VP : ~VP;
    assign valid       = dec_out.vis;
    assign line_start  = dec_out.ls;
    assign frame_start = dec_out.fs;

endmodule
